// File: rtl/demux_1x2_route_ctrl.sv
// ---------------------------------------------------------------------------
// demux_1x2_route_ctrl
// Stream-routing controller in front of a 1x2 de-multiplexer. Each accepted
// beat is captured in a one-entry holding register. The register drives the
// demux data input and select. The route is decided on the first beat of a
// packet and stays locked until the last beat. Completed packets are counted
// per output with saturating counters.
// ---------------------------------------------------------------------------
module demux_1x2_route_ctrl #(
  parameter int DATA_W  = 4,
  parameter int RR_MODE = 0,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dest,
  input  logic              in_last,
  output logic [DATA_W-1:0] dmx_in,
  output logic              dmx_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic              out_last,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  // Round-robin routing replaces destination routing when enabled.
  localparam logic             RR_EN    = (RR_MODE != 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Packet framing: SOP means the next accepted beat opens a packet.
  typedef enum logic [0:0] {
    ST_SOP = 1'b0,
    ST_PKT = 1'b1
  } state_t;

  // Saturating increment: a counter at its maximum keeps its value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (val == CNT_MAX) begin
      res = val;
    end else begin
      res = val + CNT_ONE;
    end
    return res;
  endfunction

  // Registered state.
  state_t              state_r;
  logic                route_r;
  logic                rr_ptr_r;
  logic                full_r;
  logic [DATA_W-1:0]   data_r;
  logic                sel_r;
  logic                last_r;
  logic [CNT_W-1:0]    cnt0_r;
  logic [CNT_W-1:0]    cnt1_r;

  // Next-state values.
  state_t              state_nxt_s;
  logic                route_nxt_s;
  logic                rr_ptr_nxt_s;
  logic                full_nxt_s;
  logic [DATA_W-1:0]   data_nxt_s;
  logic                sel_nxt_s;
  logic                last_nxt_s;
  logic [CNT_W-1:0]    cnt0_nxt_s;
  logic [CNT_W-1:0]    cnt1_nxt_s;

  // Handshake and routing decode.
  logic                take0_s;
  logic                take1_s;
  logic                take_s;
  logic                accept_s;
  logic                first_route_s;
  logic                beat_route_s;

  // Downstream take/upstream accept decode from the held beat.
  always_comb begin
    take0_s  = full_r & ~sel_r & out0_ready;
    take1_s  = full_r &  sel_r & out1_ready;
    take_s   = take0_s | take1_s;
    // Emptying in the same cycle frees the slot, giving one beat per cycle.
    in_ready = ~full_r | take_s;
    accept_s = in_valid & in_ready;
  end

  // Route chosen for a beat that opens a packet.
  always_comb begin
    first_route_s = 1'b0;
    if (RR_EN) begin
      first_route_s = rr_ptr_r;
    end else begin
      first_route_s = in_dest;
    end
  end

  // Packet framing FSM: next state, locked route and round-robin pointer.
  always_comb begin
    state_nxt_s  = state_r;
    route_nxt_s  = route_r;
    rr_ptr_nxt_s = rr_ptr_r;
    beat_route_s = route_r;
    case (state_r)
      ST_SOP: begin
        beat_route_s = first_route_s;
        if (accept_s) begin
          route_nxt_s = first_route_s;
          if (RR_EN) begin
            rr_ptr_nxt_s = ~rr_ptr_r;
          end else begin
            rr_ptr_nxt_s = rr_ptr_r;
          end
          if (in_last) begin
            state_nxt_s = ST_SOP;
          end else begin
            state_nxt_s = ST_PKT;
          end
        end else begin
          state_nxt_s = ST_SOP;
        end
      end
      ST_PKT: begin
        // Mid-packet beats follow the route locked on the first beat.
        beat_route_s = route_r;
        if (accept_s && in_last) begin
          state_nxt_s = ST_SOP;
        end else begin
          state_nxt_s = ST_PKT;
        end
      end
      default: begin
        beat_route_s = first_route_s;
        state_nxt_s  = ST_SOP;
      end
    endcase
  end

  // Holding register: load on accept (also when the old beat leaves), empty on take.
  always_comb begin
    full_nxt_s = full_r;
    data_nxt_s = data_r;
    sel_nxt_s  = sel_r;
    last_nxt_s = last_r;
    if (accept_s) begin
      full_nxt_s = 1'b1;
      data_nxt_s = in_data;
      sel_nxt_s  = beat_route_s;
      last_nxt_s = in_last;
    end else if (take_s) begin
      // Data/select/last keep their value; only the valid flag drops.
      full_nxt_s = 1'b0;
    end else begin
      full_nxt_s = full_r;
    end
  end

  // Completed-packet counters: count takes of a last beat per output.
  always_comb begin
    cnt0_nxt_s = cnt0_r;
    cnt1_nxt_s = cnt1_r;
    if (take0_s && last_r) begin
      cnt0_nxt_s = sat_inc(cnt0_r);
    end else begin
      cnt0_nxt_s = cnt0_r;
    end
    if (take1_s && last_r) begin
      cnt1_nxt_s = sat_inc(cnt1_r);
    end else begin
      cnt1_nxt_s = cnt1_r;
    end
  end

  // State register with asynchronous reset; a reset drops any held beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= ST_SOP;
      route_r  <= 1'b0;
      rr_ptr_r <= 1'b0;
      full_r   <= 1'b0;
      data_r   <= {DATA_W{1'b0}};
      sel_r    <= 1'b0;
      last_r   <= 1'b0;
      cnt0_r   <= {CNT_W{1'b0}};
      cnt1_r   <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      route_r  <= route_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      full_r   <= full_nxt_s;
      data_r   <= data_nxt_s;
      sel_r    <= sel_nxt_s;
      last_r   <= last_nxt_s;
      cnt0_r   <= cnt0_nxt_s;
      cnt1_r   <= cnt1_nxt_s;
    end
  end

  // Output drive straight from the holding register and counters.
  always_comb begin
    dmx_in     = data_r;
    dmx_sel    = sel_r;
    out_last   = last_r;
    out0_valid = full_r & ~sel_r;
    out1_valid = full_r &  sel_r;
    pkt_cnt0   = cnt0_r;
    pkt_cnt1   = cnt1_r;
  end

  demux_1x2_route_ctrl_chk #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_chk (
    .clk        (clk),
    .rstn       (rstn),
    .full       (full_r),
    .take       (take_s),
    .dmx_in     (data_r),
    .dmx_sel    (sel_r),
    .out_last   (last_r),
    .out0_valid (out0_valid),
    .out1_valid (out1_valid),
    .pkt_cnt0   (cnt0_r),
    .pkt_cnt1   (cnt1_r)
  );

endmodule

// ---------------------------------------------------------------------------
// demux_1x2_route_ctrl_chk
// Run-time invariants of the routing controller: one-hot output valids,
// stable held beat under backpressure, monotonic packet counters.
// ---------------------------------------------------------------------------
module demux_1x2_route_ctrl_chk #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              full,
  input  logic              take,
  input  logic [DATA_W-1:0] dmx_in,
  input  logic              dmx_sel,
  input  logic              out_last,
  input  logic              out0_valid,
  input  logic              out1_valid,
  input  logic [CNT_W-1:0]  pkt_cnt0,
  input  logic [CNT_W-1:0]  pkt_cnt1
);

  logic              stall_r;
  logic [DATA_W-1:0] data_r;
  logic              sel_r;
  logic              last_r;
  logic [CNT_W-1:0]  cnt0_r;
  logic [CNT_W-1:0]  cnt1_r;

  // Snapshot of the previous cycle's held beat, stall condition and counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
      sel_r   <= 1'b0;
      last_r  <= 1'b0;
      cnt0_r  <= {CNT_W{1'b0}};
      cnt1_r  <= {CNT_W{1'b0}};
    end else begin
      stall_r <= full & ~take;
      data_r  <= dmx_in;
      sel_r   <= dmx_sel;
      last_r  <= out_last;
      cnt0_r  <= pkt_cnt0;
      cnt1_r  <= pkt_cnt1;
    end
  end

  // Invariant checks against the snapshot taken one cycle earlier.
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(out0_valid && out1_valid));
      assert (pkt_cnt0 >= cnt0_r);
      assert (pkt_cnt1 >= cnt1_r);
      if (stall_r) begin
        assert ((dmx_in == data_r) && (dmx_sel == sel_r) && (out_last == last_r));
      end
    end
  end

endmodule

// File: tb/tb_demux_1x2_route_ctrl.sv
// ---------------------------------------------------------------------------
// tb_demux_1x2_route_ctrl
// Directed bench. Instance a: destination routing, 2-bit counters.
// Instance b: round-robin routing, 8-bit counters. The use_b flag
// steers in_valid and selects which instance is observed.
// ---------------------------------------------------------------------------
module tb_demux_1x2_route_ctrl;

  logic       clk;
  logic       rstn;
  logic       use_b;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_dest;
  logic       in_last;
  logic       out0_ready;
  logic       out1_ready;

  logic       a_in_valid, b_in_valid;
  logic       a_in_ready, b_in_ready;
  logic [3:0] a_dmx_in, b_dmx_in;
  logic       a_dmx_sel, b_dmx_sel;
  logic       a_out0_valid, b_out0_valid;
  logic       a_out1_valid, b_out1_valid;
  logic       a_out_last, b_out_last;
  logic [1:0] a_pkt_cnt0, a_pkt_cnt1;
  logic [7:0] b_pkt_cnt0, b_pkt_cnt1;

  logic       o_in_ready, o_dmx_sel, o_out0_valid, o_out1_valid, o_out_last;
  logic [3:0] o_dmx_in;
  logic [7:0] o_cnt0, o_cnt1;

  int vec_cnt = 0;
  int err_cnt = 0;

  assign a_in_valid = in_valid & ~use_b;
  assign b_in_valid = in_valid &  use_b;

  assign o_in_ready   = use_b ? b_in_ready   : a_in_ready;
  assign o_dmx_in     = use_b ? b_dmx_in     : a_dmx_in;
  assign o_dmx_sel    = use_b ? b_dmx_sel    : a_dmx_sel;
  assign o_out0_valid = use_b ? b_out0_valid : a_out0_valid;
  assign o_out1_valid = use_b ? b_out1_valid : a_out1_valid;
  assign o_out_last   = use_b ? b_out_last   : a_out_last;
  assign o_cnt0       = use_b ? b_pkt_cnt0   : {6'd0, a_pkt_cnt0};
  assign o_cnt1       = use_b ? b_pkt_cnt1   : {6'd0, a_pkt_cnt1};

  demux_1x2_route_ctrl #(.DATA_W(4), .RR_MODE(0), .CNT_W(2)) u_dut_a (
    .clk(clk), .rstn(rstn), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
    .dmx_in(a_dmx_in), .dmx_sel(a_dmx_sel),
    .out0_valid(a_out0_valid), .out0_ready(out0_ready),
    .out1_valid(a_out1_valid), .out1_ready(out1_ready),
    .out_last(a_out_last), .pkt_cnt0(a_pkt_cnt0), .pkt_cnt1(a_pkt_cnt1)
  );

  demux_1x2_route_ctrl #(.DATA_W(4), .RR_MODE(1), .CNT_W(8)) u_dut_b (
    .clk(clk), .rstn(rstn), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
    .dmx_in(b_dmx_in), .dmx_sel(b_dmx_sel),
    .out0_valid(b_out0_valid), .out0_ready(out0_ready),
    .out1_valid(b_out1_valid), .out1_ready(out1_ready),
    .out_last(b_out_last), .pkt_cnt0(b_pkt_cnt0), .pkt_cnt1(b_pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the sequence ever stops advancing.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic dst, input logic lst);
    in_valid = v;
    in_data  = d;
    in_dest  = dst;
    in_last  = lst;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rstn     = 1'b0;
    tick();
    tick();
    rstn     = 1'b1;
  endtask

  initial begin
    use_b      = 1'b0;
    rstn       = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0);

    // Reset state.
    tick();
    tick();
    #1;
    chk("rst_out0_valid", 32'(o_out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(o_out1_valid), 32'd0);
    chk("rst_dmx_in",     32'(o_dmx_in),     32'd0);
    chk("rst_dmx_sel",    32'(o_dmx_sel),    32'd0);
    chk("rst_out_last",   32'(o_out_last),   32'd0);
    chk("rst_cnt0",       32'(o_cnt0),       32'd0);
    chk("rst_cnt1",       32'(o_cnt1),       32'd0);
    tick();
    rstn = 1'b1;
    #1;
    chk("rst_in_ready",   32'(o_in_ready),   32'd1);

    // Two single-beat packets, dest 1 then dest 0.
    tick();
    drive(1'b1, 4'd3, 1'b1, 1'b1);
    #1;
    chk("t1_in_ready0", 32'(o_in_ready), 32'd1);
    tick();
    drive(1'b1, 4'd5, 1'b0, 1'b1);
    #1;
    chk("t1_out1_valid", 32'(o_out1_valid), 32'd1);
    chk("t1_out0_idle",  32'(o_out0_valid), 32'd0);
    chk("t1_dmx_in_3",   32'(o_dmx_in),     32'd3);
    chk("t1_dmx_sel_1",  32'(o_dmx_sel),    32'd1);
    chk("t1_out_last",   32'(o_out_last),   32'd1);
    chk("t1_in_ready1",  32'(o_in_ready),   32'd1);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    chk("t1_out0_valid", 32'(o_out0_valid), 32'd1);
    chk("t1_dmx_in_5",   32'(o_dmx_in),     32'd5);
    chk("t1_cnt1_mid",   32'(o_cnt1),       32'd1);
    chk("t1_cnt0_mid",   32'(o_cnt0),       32'd0);
    tick();
    #1;
    chk("t1_drained0",   32'(o_out0_valid), 32'd0);
    chk("t1_drained1",   32'(o_out1_valid), 32'd0);
    chk("t1_cnt0",       32'(o_cnt0),       32'd1);
    chk("t1_cnt1",       32'(o_cnt1),       32'd1);

    // Three-beat packet to out0 with in_dest toggling after the first beat.
    do_reset();
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd2, 1'b1, 1'b0);
    #1;
    chk("t2_b1_out0",  32'(o_out0_valid), 32'd1);
    chk("t2_b1_data",  32'(o_dmx_in),     32'd1);
    chk("t2_b1_last",  32'(o_out_last),   32'd0);
    tick();
    drive(1'b1, 4'd4, 1'b1, 1'b1);
    #1;
    chk("t2_b2_out0",  32'(o_out0_valid), 32'd1);
    chk("t2_b2_out1",  32'(o_out1_valid), 32'd0);
    chk("t2_b2_data",  32'(o_dmx_in),     32'd2);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    chk("t2_b3_out0",  32'(o_out0_valid), 32'd1);
    chk("t2_b3_data",  32'(o_dmx_in),     32'd4);
    chk("t2_b3_last",  32'(o_out_last),   32'd1);
    chk("t2_cnt0_pre", 32'(o_cnt0),       32'd0);
    tick();
    #1;
    chk("t2_cnt0",     32'(o_cnt0),       32'd1);
    chk("t2_cnt1",     32'(o_cnt1),       32'd0);

    // Backpressure on out1 for four cycles while a second beat waits.
    do_reset();
    out1_ready = 1'b0;
    drive(1'b1, 4'd9, 1'b1, 1'b1);
    tick();
    drive(1'b1, 4'd6, 1'b0, 1'b1);
    #1;
    chk("t3_stall_valid", 32'(o_out1_valid), 32'd1);
    chk("t3_stall_rdy0",  32'(o_in_ready),   32'd0);
    chk("t3_stall_data0", 32'(o_dmx_in),     32'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("t3_stall_rdy",  32'(o_in_ready), 32'd0);
      chk("t3_stall_data", 32'(o_dmx_in),   32'd9);
      chk("t3_stall_sel",  32'(o_dmx_sel),  32'd1);
    end
    tick();
    out1_ready = 1'b1;
    #1;
    chk("t3_release_rdy", 32'(o_in_ready), 32'd1);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    chk("t3_next_out0",   32'(o_out0_valid), 32'd1);
    chk("t3_next_data",   32'(o_dmx_in),     32'd6);
    chk("t3_cnt1",        32'(o_cnt1),       32'd1);
    tick();
    #1;
    chk("t3_cnt0",        32'(o_cnt0),       32'd1);

    // Reset after beat 2 of a 4-beat packet routed to out1.
    drive(1'b1, 4'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    chk("t5_pre_out1", 32'(o_out1_valid), 32'd1);
    chk("t5_pre_data", 32'(o_dmx_in),     32'd2);
    rstn = 1'b0;
    #1;
    chk("t5_rst_out0", 32'(o_out0_valid), 32'd0);
    chk("t5_rst_out1", 32'(o_out1_valid), 32'd0);
    chk("t5_rst_cnt0", 32'(o_cnt0),       32'd0);
    chk("t5_rst_cnt1", 32'(o_cnt1),       32'd0);
    tick();
    rstn = 1'b1;
    drive(1'b1, 4'd7, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd8, 1'b1, 1'b1);
    #1;
    chk("t5_new_out0", 32'(o_out0_valid), 32'd1);
    chk("t5_new_sel",  32'(o_dmx_sel),    32'd0);
    chk("t5_new_data", 32'(o_dmx_in),     32'd7);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    chk("t5_end_out0", 32'(o_out0_valid), 32'd1);
    chk("t5_end_data", 32'(o_dmx_in),     32'd8);
    chk("t5_end_last", 32'(o_out_last),   32'd1);
    tick();
    #1;
    chk("t5_cnt0",     32'(o_cnt0),       32'd1);
    chk("t5_cnt1",     32'(o_cnt1),       32'd0);

    // Six single-beat packets to out0 on the 2-bit counter instance.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    #1;
    chk("t6_cnt0_sat", 32'(o_cnt0), 32'd3);
    chk("t6_cnt1",     32'(o_cnt1), 32'd0);

    // Round-robin instance: four single-beat packets, all with dest 0.
    use_b = 1'b1;
    do_reset();
    drive(1'b1, 4'd1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 4'd2, 1'b0, 1'b1);
    #1;
    chk("t4_p0_out0", 32'(o_out0_valid), 32'd1);
    chk("t4_p0_data", 32'(o_dmx_in),     32'd1);
    tick();
    drive(1'b1, 4'd3, 1'b0, 1'b1);
    #1;
    chk("t4_p1_out1", 32'(o_out1_valid), 32'd1);
    chk("t4_p1_data", 32'(o_dmx_in),     32'd2);
    tick();
    drive(1'b1, 4'd4, 1'b0, 1'b1);
    #1;
    chk("t4_p2_out0", 32'(o_out0_valid), 32'd1);
    chk("t4_p2_data", 32'(o_dmx_in),     32'd3);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    chk("t4_p3_out1", 32'(o_out1_valid), 32'd1);
    chk("t4_p3_data", 32'(o_dmx_in),     32'd4);
    tick();
    #1;
    chk("t4_cnt0",    32'(o_cnt0),       32'd2);
    chk("t4_cnt1",    32'(o_cnt1),       32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
